id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Upstream neighbour of the 3-bit-control ALU in the pipelined MIPS core; sits at the ID/EX boundary.
- Registers decoded operands and control from ID each cycle.
- Applies EX/MEM and MEM/WB forwarding, selects the immediate, and drives the ALU's A, B and ALUcontrol inputs.
- Detects load-use hazards and requests a one-cycle stall; also services branch/jump flushes.

Parameters:
- DATA_W, 32, datapath width.
- REG_AW, 5, register-file address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs_data, id_rt_data  in  DATA_W  register-file read data.
- id_imm  in  DATA_W  sign/zero-extended immediate.
- id_rs, id_rt, id_rd  in  REG_AW  source/destination register numbers.
- id_uses_rt  in  1  instruction reads rt as a source.
- id_alu_src  in  1  1 selects the immediate for B.
- id_alu_control  in  3  ALU op code (000 add … 111 sltu).
- id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  control bits.
- flush  in  1  branch/jump taken; kill the instruction entering EX.
- exmem_reg_write  in  1  EX/MEM write enable.
- exmem_rd  in  REG_AW  EX/MEM destination register.
- exmem_result  in  DATA_W  EX/MEM ALU result.
- memwb_reg_write  in  1  MEM/WB write enable.
- memwb_rd  in  REG_AW  MEM/WB destination register.
- memwb_result  in  DATA_W  MEM/WB write-back data.
- stall_o  out  1  load-use hazard; PC and IF/ID must hold.
- alu_a, alu_b  out  DATA_W  to ALU A and B.
- alu_control  out  3  to ALUcontrol.
- ex_valid  out  1  EX holds a real instruction.
- ex_rd  out  REG_AW  destination register passed to EX/MEM.
- ex_store_data  out  DATA_W  forwarded rt value for stores.
- ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg  out  1  registered control bits.

Behaviour:
- Reset (rst_n=0, asynchronous): every register clears.
  - Outputs ex_valid, ex_* controls, ex_rd and alu_control are 0.
  - alu_a and alu_b are 0 while neither forwarding input matches.
- Latency: one clk from ID inputs to the registered EX state. Forwarding muxes are combinational on that registered state.
- stall_o is combinational:
  - stall_o = ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs) | (id_uses_rt & ex_rd == id_rt)).
- Capture priority on each rising edge:
  - flush: load a bubble (ex_valid=0, all write/mem controls 0, alu_control=000, data fields 0).
  - else stall_o: load a bubble; ID is held by upstream and re-presented next cycle.
  - else: capture all ID inputs; ex_valid = id_valid.
  - Flush overrides stall when both are active.
- When id_valid=0, write/mem controls are captured as 0, so a bubble never causes a write.
- Forwarding of fwd_rs, computed from the registered rs:
  - If exmem_reg_write & exmem_rd != 0 & exmem_rd == ex_rs, select exmem_result.
  - Else if memwb_reg_write & memwb_rd != 0 & memwb_rd == ex_rs, select memwb_result.
  - Else select the registered rs data.
  - fwd_rt uses the same rule on ex_rt.
  - EX/MEM always wins over MEM/WB; register 0 is never forwarded.
- Output selection:
  - alu_a = fwd_rs.
  - alu_b = ex_alu_src ? ex_imm : fwd_rt.
  - ex_store_data = fwd_rt, regardless of ex_alu_src.
- A stall lasts exactly one cycle per load-use pair. The next cycle EX holds the bubble, so stall_o deasserts.
- Reset asserted mid-stall or mid-flush clears state immediately; no pending bubble survives reset.

Optional Feature:
- Macro ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt and flush_cnt (32 bits each).
  - Each counts cycles with stall_o=1 and with flush=1, respectively.
  - Both wrap at 2^32 and clear on reset.
  - A cycle with flush and stall together increments both.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset, then release with id_valid=1, rs_data=5, rt_data=7, alu_control=000, alu_src=0 → next cycle alu_a=5, alu_b=7, alu_control=000, ex_valid=1.
- EX rs=$3, with exmem (we=1, rd=3, result=0x10) and memwb (we=1, rd=3, result=0x20) → alu_a=0x10; drop exmem_reg_write → alu_a=0x20.
- exmem_rd=0, exmem_result=0xFFFF_FFFF, exmem_reg_write=1, ex_rs=0, rs_data=0 → alu_a=0, no forwarding.
- lw into $8 in EX, ID add reading $8 as rt with id_uses_rt=1 → stall_o=1 for exactly one cycle; EX gets a bubble (ex_reg_write=0); the add enters the following cycle.
- flush=1 together with a load-use stall → bubble loaded, ex_valid=0; with ID_EX_PERF_CNT_EN, stall_cnt and flush_cnt each increment by 1.
- alu_src=1, imm=0xFFFF_FFFC, rt forwarded from memwb=0x55 → alu_b=0xFFFF_FFFC, ex_store_data=0x55.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, immediate select and load-use stall detection.
// Optional ID_EX_PERF_CNT_EN adds stall_cnt/flush_cnt cycle counters.
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_uses_rt,
  input  logic              id_alu_src,
  input  logic [2:0]        id_alu_control,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              flush,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              stall_o,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [2:0]        alu_control,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);
  logic              ex_valid_q, ex_valid_d;
  logic [REG_AW-1:0] ex_rs_q, ex_rs_d, ex_rt_q, ex_rt_d, ex_rd_q, ex_rd_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d, ex_rt_data_q, ex_rt_data_d, ex_imm_q, ex_imm_d;
  logic              ex_alu_src_q, ex_alu_src_d;
  logic [2:0]        alu_control_q, alu_control_d;
  logic              ex_reg_write_q, ex_reg_write_d, ex_mem_read_q, ex_mem_read_d;
  logic              ex_mem_write_q, ex_mem_write_d, ex_mem_to_reg_q, ex_mem_to_reg_d;
  logic              keep, live;
  logic [DATA_W-1:0] fwd_rs, fwd_rt;
  always_comb begin
    stall_o = ex_valid_q && ex_mem_read_q && (ex_rd_q != '0) &&
              ((ex_rd_q == id_rs) || (id_uses_rt && (ex_rd_q == id_rt)));
    keep = !flush && !stall_o;
    live = keep && id_valid;
    ex_valid_d      = live;
    ex_rs_d         = keep ? id_rs : '0;
    ex_rt_d         = keep ? id_rt : '0;
    ex_rd_d         = keep ? id_rd : '0;
    ex_rs_data_d    = keep ? id_rs_data : '0;
    ex_rt_data_d    = keep ? id_rt_data : '0;
    ex_imm_d        = keep ? id_imm : '0;
    ex_alu_src_d    = keep && id_alu_src;
    alu_control_d   = keep ? id_alu_control : 3'b000;
    ex_reg_write_d  = live && id_reg_write;
    ex_mem_read_d   = live && id_mem_read;
    ex_mem_write_d  = live && id_mem_write;
    ex_mem_to_reg_d = live && id_mem_to_reg;
  end
  // EX/MEM is the younger producer, so it takes priority; $0 is never forwarded.
  always_comb begin
    fwd_rs = (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rs_q) ? exmem_result :
             (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rs_q) ? memwb_result : ex_rs_data_q;
    fwd_rt = (exmem_reg_write && exmem_rd != '0 && exmem_rd == ex_rt_q) ? exmem_result :
             (memwb_reg_write && memwb_rd != '0 && memwb_rd == ex_rt_q) ? memwb_result : ex_rt_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q      <= 1'b0;
      ex_rs_q         <= '0;
      ex_rt_q         <= '0;
      ex_rd_q         <= '0;
      ex_rs_data_q    <= '0;
      ex_rt_data_q    <= '0;
      ex_imm_q        <= '0;
      ex_alu_src_q    <= 1'b0;
      alu_control_q   <= 3'b000;
      ex_reg_write_q  <= 1'b0;
      ex_mem_read_q   <= 1'b0;
      ex_mem_write_q  <= 1'b0;
      ex_mem_to_reg_q <= 1'b0;
    end else begin
      ex_valid_q      <= ex_valid_d;
      ex_rs_q         <= ex_rs_d;
      ex_rt_q         <= ex_rt_d;
      ex_rd_q         <= ex_rd_d;
      ex_rs_data_q    <= ex_rs_data_d;
      ex_rt_data_q    <= ex_rt_data_d;
      ex_imm_q        <= ex_imm_d;
      ex_alu_src_q    <= ex_alu_src_d;
      alu_control_q   <= alu_control_d;
      ex_reg_write_q  <= ex_reg_write_d;
      ex_mem_read_q   <= ex_mem_read_d;
      ex_mem_write_q  <= ex_mem_write_d;
      ex_mem_to_reg_q <= ex_mem_to_reg_d;
    end
  end
  assign alu_a         = fwd_rs;
  assign alu_b         = ex_alu_src_q ? ex_imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_control   = alu_control_q;
  assign ex_valid      = ex_valid_q;
  assign ex_rd         = ex_rd_q;
  assign ex_reg_write  = ex_reg_write_q;
  assign ex_mem_read   = ex_mem_read_q;
  assign ex_mem_write  = ex_mem_write_q;
  assign ex_mem_to_reg = ex_mem_to_reg_q;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
  always_comb begin
    stall_cnt_d = stall_cnt_q + 32'(stall_o);
    flush_cnt_d = flush_cnt_q + 32'(flush);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for id_ex_stage against a transaction-level pipeline model.
module tb_id_ex_stage;
  logic clk, rst_n, id_valid, id_uses_rt, id_alu_src;
  logic [31:0] id_rs_data, id_rt_data, id_imm, exmem_result, memwb_result;
  logic [4:0] id_rs, id_rt, id_rd, exmem_rd, memwb_rd;
  logic [2:0] id_alu_control, alu_control;
  logic id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, flush;
  logic exmem_reg_write, memwb_reg_write;
  logic stall_o, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [4:0] ex_rd;
`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rt(id_uses_rt),
    .id_alu_src(id_alu_src), .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .stall_o(stall_o), .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_store_data(ex_store_data), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
`ifdef ID_EX_PERF_CNT_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  typedef struct packed {
    logic rst_n, valid, uses_rt, alu_src, rw, mr, mw, m2r, flush, xw, ww;
    logic [31:0] rsd, rtd, imm, xres, wres;
    logic [4:0] rs, rt, rd, xrd, wrd;
    logic [2:0] aluc;
  } stim_t;

  // An instruction sitting in EX, as the pipeline sees it.
  typedef struct packed {
    logic v, src, rw, mr, mw, m2r;
    logic [4:0] rs, rt, rd;
    logic [31:0] rsd, rtd, imm;
    logic [2:0] aluc;
  } instr_t;

  typedef struct packed {
    logic stall, v, rw, mr, mw, m2r;
    logic [31:0] a, b, sd, sc, fc;
    logic [4:0] rd;
    logic [2:0] aluc;
  } exp_t;

  exp_t q[$];
  instr_t m;
  logic [31:0] sc_m, fc_m;
  int checks = 0, errors = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] source(input stim_t s, input logic [4:0] r, input logic [31:0] d);
    if (r == 0) return d;
    if (s.xw && s.xrd == r) return s.xres;
    if (s.ww && s.wrd == r) return s.wres;
    return d;
  endfunction

  function automatic stim_t idle();
    stim_t s = '0;
    s.rst_n = 1;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rst_n = ($urandom_range(0, 199) != 0);
    s.valid = ($urandom_range(0, 7) != 0);
    s.uses_rt = $urandom; s.alu_src = $urandom; s.rw = $urandom; s.mr = ($urandom_range(0, 2) == 0);
    s.mw = $urandom; s.m2r = $urandom; s.flush = ($urandom_range(0, 9) == 0);
    s.xw = $urandom; s.ww = $urandom;
    s.rsd = $urandom; s.rtd = $urandom; s.imm = $urandom; s.xres = $urandom; s.wres = $urandom;
    s.rs = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
    s.rt = 5'($urandom_range(0, 3)); s.rd = 5'($urandom_range(0, 3));
    s.xrd = 5'($urandom_range(0, 3)); s.wrd = 5'($urandom_range(0, 3));
    s.aluc = 3'($urandom);
    return s;
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    logic st;
    @(negedge clk);
    rst_n = s.rst_n; id_valid = s.valid; id_uses_rt = s.uses_rt; id_alu_src = s.alu_src;
    id_reg_write = s.rw; id_mem_read = s.mr; id_mem_write = s.mw; id_mem_to_reg = s.m2r;
    flush = s.flush; exmem_reg_write = s.xw; memwb_reg_write = s.ww;
    id_rs_data = s.rsd; id_rt_data = s.rtd; id_imm = s.imm; exmem_result = s.xres; memwb_result = s.wres;
    id_rs = s.rs; id_rt = s.rt; id_rd = s.rd; exmem_rd = s.xrd; memwb_rd = s.wrd; id_alu_control = s.aluc;
    if (!s.rst_n) begin m = '0; sc_m = 0; fc_m = 0; end
    st = m.v && m.mr && m.rd != 0 && (m.rd == s.rs || (s.uses_rt && m.rd == s.rt));
    e.stall = st; e.v = m.v; e.rw = m.rw; e.mr = m.mr; e.mw = m.mw; e.m2r = m.m2r;
    e.a = source(s, m.rs, m.rsd);
    e.sd = source(s, m.rt, m.rtd);
    e.b = m.src ? m.imm : e.sd;
    e.sc = sc_m; e.fc = fc_m; e.rd = m.rd; e.aluc = m.aluc;
    q.push_back(e);
    if (s.rst_n) begin
      sc_m += 32'(st);
      fc_m += 32'(s.flush);
      if (s.flush || st) m = '0;
      else begin
        m.v = s.valid; m.src = s.alu_src; m.rs = s.rs; m.rt = s.rt; m.rd = s.rd;
        m.rsd = s.rsd; m.rtd = s.rtd; m.imm = s.imm; m.aluc = s.aluc;
        m.rw = s.valid && s.rw; m.mr = s.valid && s.mr; m.mw = s.valid && s.mw; m.m2r = s.valid && s.m2r;
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("stall_o", 32'(stall_o), 32'(e.stall));
        chk("alu_a", alu_a, e.a);
        chk("alu_b", alu_b, e.b);
        chk("store_data", ex_store_data, e.sd);
        chk("alu_control", 32'(alu_control), 32'(e.aluc));
        chk("ex_valid", 32'(ex_valid), 32'(e.v));
        chk("ex_rd", 32'(ex_rd), 32'(e.rd));
        chk("ex_ctl", {28'd0, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg},
            {28'd0, e.rw, e.mr, e.mw, e.m2r});
`ifdef ID_EX_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, e.sc);
        chk("flush_cnt", flush_cnt, e.fc);
`endif
      end
    end
  end

  initial begin
    stim_t s;
    rst_n = 0;
    s = idle(); s.rst_n = 0;
    step(s); step(s);
    s = idle(); s.valid = 1; s.rsd = 5; s.rtd = 7; s.rs = 1; s.rt = 2; s.rw = 1;
    step(s);
    s = idle(); s.valid = 1; s.rs = 3; s.rsd = 32'h99; s.rt = 4;
    step(s);
    s.xw = 1; s.xrd = 3; s.xres = 32'h10; s.ww = 1; s.wrd = 3; s.wres = 32'h20;
    step(s);
    s.xw = 0;
    step(s);
    s = idle(); s.valid = 1; s.rs = 0; s.rsd = 0;
    step(s);
    s.xw = 1; s.xrd = 0; s.xres = 32'hFFFF_FFFF;
    step(s);
    s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.m2r = 1; s.rd = 8;
    step(s);
    s = idle(); s.valid = 1; s.rs = 1; s.rt = 8; s.uses_rt = 1; s.rw = 1; s.rd = 9;
    step(s); step(s); step(idle());
    s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.rd = 8;
    step(s);
    s = idle(); s.valid = 1; s.rs = 8; s.rw = 1; s.flush = 1;
    step(s); step(idle());
    s = idle(); s.valid = 1; s.mr = 1; s.rw = 1; s.rd = 8;
    step(s);
    s = idle(); s.valid = 1; s.rs = 8; s.rst_n = 0;
    step(s); step(idle());
    s = idle(); s.valid = 1; s.alu_src = 1; s.imm = 32'hFFFF_FFFC; s.rt = 5; s.rtd = 1; s.mw = 1;
    step(s);
    s.ww = 1; s.wrd = 5; s.wres = 32'h55;
    step(s);
    for (int i = 0; i < 3000; i++) step(rnd());
    step(idle());
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #5;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
